// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
package seg7_pkg;

  // Active-low "everything off" patterns.
  localparam logic [7:0] SEG_DARK = 8'hFF;
  localparam logic [3:0] AN_OFF   = 4'hF;

  // Digit index: digit 0 is the rightmost digit.
  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_FIRST = 2'd0;
  localparam digit_idx_t DIGIT_LAST  = 2'd3;

  // Active-low glyphs, bit7 = dp (off), bits 6:0 = g..a; indexed by nibble.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph (segments g..a only).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  // Table lookup; the dp bit is handled by the caller.
  always_comb begin
    o_glyph = GLYPH_TABLE[i_nibble][6:0];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A shadow/active register pair keeps each displayed frame consistent.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  logic [15:0]      r_shadow_val;
  logic [3:0]       r_shadow_dp;
  logic [15:0]      r_active_val;
  logic [3:0]       r_active_dp;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_frame;

  logic             w_wrap;
  logic             w_frame_bnd;
  logic             w_dead;
  logic             w_lz_dark;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;
  logic [7:0]       w_seg_next;
  logic [3:0]       w_an_next;
  logic             w_frame_next;

  assign w_wrap       = (r_cnt == CNT_LAST);
  assign w_frame_bnd  = w_wrap && (r_idx == DIGIT_LAST);
  assign w_dead       = (r_cnt < CNT_BLANK);
  assign w_nibble     = r_active_val[{r_idx, 2'b00} +: 4];
  assign w_frame_next = (r_cnt == '0) && (r_idx == DIGIT_FIRST);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Slot counter and digit index; the index steps on every counter wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= DIGIT_FIRST;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: load fills the shadow; active updates only at the frame
  // boundary, taking a same-cycle load directly rather than the stale shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
    end else begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_en;
      end
      if (w_frame_bnd) begin
        r_active_val <= load ? value : r_shadow_val;
        r_active_dp  <= load ? dp_en : r_shadow_dp;
      end
    end
  end

  // Leading-zero test: digit k is dark when nibbles k..3 are all zero.
  always_comb begin
    w_lz_dark = 1'b0;
    if (lz_blank) begin
      unique case (r_idx)
        2'd1:    w_lz_dark = (r_active_val[15:4]  == 12'h000);
        2'd2:    w_lz_dark = (r_active_val[15:8]  == 8'h00);
        2'd3:    w_lz_dark = (r_active_val[15:12] == 4'h0);
        default: w_lz_dark = 1'b0;
      endcase
    end
  end

  // Next pin values: dark during dead time or blanking, else one digit lit.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_DARK;
    if (!w_dead && !w_lz_dark) begin
      w_an_next  = ~(4'b0001 << r_idx);
      w_seg_next = {~r_active_dp[r_idx], w_glyph};
    end
  end

  // Registered pin drivers, one clock behind the counter/index state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= SEG_DARK;
      r_an    <= AN_OFF;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_next;
      r_an    <= w_an_next;
      r_frame <= w_frame_next;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;

endmodule
